// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: state encoding, CTI codes, default watchdog width.
// The ABORT state exists only when WB_RR_ARBITER_WDOG_EN is defined.
package wb_arb_pkg;

  localparam int WB_TMO_W_DEF = 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

`ifdef WB_RR_ARBITER_WDOG_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } arb_state_e;
`endif

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin search: first requester after cur_owner, wrapping, with cur_owner itself considered last.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int OW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] cur_owner,
  output logic [OW-1:0] next_owner,
  output logic          any_req
);

  logic found_s;

  // Priority scan starting one past the current owner.
  always_comb begin
    next_owner = cur_owner;
    found_s    = 1'b0;
    any_req    = |req;
    for (int i = 1; i <= N; i++) begin
      if (!found_s && req[(int'(cur_owner) + i) % N]) begin
        next_owner = OW'((int'(cur_owner) + i) % N);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone N-master round-robin arbiter: registered owner, zero-latency bus and response muxing.
// Define WB_RR_ARBITER_WDOG_EN to add the stalled-transfer watchdog with ABORT state.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NMASTERS = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int TMO_W    = WB_TMO_W_DEF
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [NMASTERS*AW-1:0]      wbm_adr_i,
  input  logic [NMASTERS*DW-1:0]      wbm_dat_i,
  input  logic [NMASTERS*DW/8-1:0]    wbm_sel_i,
  input  logic [NMASTERS*3-1:0]       wbm_cti_i,
  input  logic [NMASTERS*2-1:0]       wbm_bte_i,
  input  logic [NMASTERS-1:0]         wbm_cyc_i,
  input  logic [NMASTERS-1:0]         wbm_stb_i,
  input  logic [NMASTERS-1:0]         wbm_we_i,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [NMASTERS-1:0]         wbm_ack_o,
  output logic [NMASTERS-1:0]         wbm_err_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  input  logic [DW-1:0]               wbs_dat_i,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  output logic [$clog2(NMASTERS)-1:0] owner_o
);

  localparam int OW = $clog2(NMASTERS);
  localparam int SW = DW / 8;

  logic [OW-1:0] owner_r;
  logic [OW-1:0] pick_next_s;
  logic          pick_any_s;
  arb_state_e    state_r;
  arb_state_e    state_s;
  logic          rst_hold_r;
  logic          gate_s;
  logic          abort_s;
  logic          own_cyc_s;
  logic          own_stb_s;
  logic          drive_s;
  logic          term_ok_s;
  logic          wdog_fire_s;

  wb_rr_pick #(.N(NMASTERS), .OW(OW)) u_pick (
    .req        (wbm_cyc_i),
    .cur_owner  (owner_r),
    .next_owner (pick_next_s),
    .any_req    (pick_any_s)
  );

  assign own_cyc_s = wbm_cyc_i[owner_r];
  assign own_stb_s = wbm_stb_i[owner_r];
  // Bus stays quiet while reset is held and for the first cycle after it.
  assign gate_s    = wb_rst_i | rst_hold_r;
  assign drive_s   = own_cyc_s & ~gate_s & ~abort_s;
  assign term_ok_s = ~gate_s & ~abort_s;

  assign wbs_adr_o = wbm_adr_i[int'(owner_r)*AW +: AW];
  assign wbs_dat_o = wbm_dat_i[int'(owner_r)*DW +: DW];
  assign wbs_sel_o = wbm_sel_i[int'(owner_r)*SW +: SW];
  assign wbs_cti_o = wbm_cti_i[int'(owner_r)*3 +: 3];
  assign wbs_bte_o = wbm_bte_i[int'(owner_r)*2 +: 2];
  assign wbs_we_o  = wbm_we_i[owner_r];
  assign wbs_cyc_o = drive_s;
  assign wbs_stb_o = drive_s & own_stb_s;
  assign wbm_dat_o = wbs_dat_i;
  assign owner_o   = owner_r;

  // Route slave termination to the owner only.
  always_comb begin
    wbm_ack_o          = '0;
    wbm_err_o          = '0;
    wbm_ack_o[owner_r] = wbs_ack_i & term_ok_s;
    wbm_err_o[owner_r] = (wbs_err_i & term_ok_s) | wdog_fire_s;
  end

`ifdef WB_RR_ARBITER_WDOG_EN
  logic [TMO_W-1:0] wdog_cnt_r;
  logic             wdog_run_s;

  assign abort_s     = (state_r == ST_ABORT);
  assign wdog_run_s  = own_cyc_s & own_stb_s & term_ok_s & ~wbs_ack_i & ~wbs_err_i;
  assign wdog_fire_s = wdog_run_s & (wdog_cnt_r == {TMO_W{1'b1}});

  // Stall counter; a run cannot span an owner change since it requires the owner's cyc.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wdog_cnt_r <= '0;
    end else if (wdog_run_s && !wdog_fire_s) begin
      wdog_cnt_r <= wdog_cnt_r + TMO_W'(1);
    end else begin
      wdog_cnt_r <= '0;
    end
  end
`else
  logic [TMO_W-1:0] wdog_unused_s;

  assign wdog_unused_s = '0;
  assign abort_s       = 1'b0;
  assign wdog_fire_s   = 1'b0;
`endif

  // Owner, state and post-reset hold registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner_r    <= '0;
      state_r    <= ST_IDLE;
      rst_hold_r <= 1'b1;
    end else begin
      rst_hold_r <= 1'b0;
      state_r    <= state_s;
      if (!own_cyc_s && pick_any_s) begin
        owner_r <= pick_next_s;
      end else begin
        owner_r <= owner_r;
      end
    end
  end

  // Next-state logic; leaving BUSY/ABORT coincides with the owner dropping cyc.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (own_cyc_s) state_s = ST_BUSY;
        else           state_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (!own_cyc_s)       state_s = ST_IDLE;
`ifdef WB_RR_ARBITER_WDOG_EN
        else if (wdog_fire_s) state_s = ST_ABORT;
`endif
        else                  state_s = ST_BUSY;
      end
`ifdef WB_RR_ARBITER_WDOG_EN
      ST_ABORT: begin
        if (!own_cyc_s) state_s = ST_IDLE;
        else            state_s = ST_ABORT;
      end
`endif
      default: state_s = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter (4 masters, TMO_W=4).
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 4;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic [NM*AW-1:0]  wbm_adr_i;
  logic [NM*DW-1:0]  wbm_dat_i;
  logic [NM*DW/8-1:0] wbm_sel_i;
  logic [NM*3-1:0]   wbm_cti_i;
  logic [NM*2-1:0]   wbm_bte_i;
  logic [NM-1:0]     wbm_cyc_i;
  logic [NM-1:0]     wbm_stb_i;
  logic [NM-1:0]     wbm_we_i;
  logic [DW-1:0]     wbm_dat_o;
  logic [NM-1:0]     wbm_ack_o;
  logic [NM-1:0]     wbm_err_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_cyc_o;
  logic              wbs_stb_o;
  logic              wbs_we_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i;
  logic              wbs_err_i;
  logic [1:0]        owner_o;

  int vectors     = 0;
  int miscompares = 0;
  int ord[5]      = '{0, 1, 2, 3, 0};

  always #5 wb_clk_i = ~wb_clk_i;

  wb_rr_arbiter #(.NMASTERS(NM), .AW(AW), .DW(DW), .TMO_W(TW)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_cti_i (wbm_cti_i),
    .wbm_bte_i (wbm_bte_i),
    .wbm_cyc_i (wbm_cyc_i),
    .wbm_stb_i (wbm_stb_i),
    .wbm_we_i  (wbm_we_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .owner_o   (owner_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_cti(input int k, input logic [2:0] v);
    wbm_cti_i[k*3 +: 3] = v;
  endtask

  function automatic logic [31:0] adr_of(input int k);
    return 32'hA000_0000 + 32'(k) * 32'h0000_0010;
  endfunction

  function automatic logic [31:0] dat_of(input int k);
    return 32'hD000_0000 + 32'(k);
  endfunction

  initial begin
    wb_rst_i  = 1'b1;
    wbm_cyc_i = 4'b0000;
    wbm_stb_i = 4'b0000;
    wbm_we_i  = 4'b0000;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    wbs_dat_i = 32'h0000_0000;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    for (int k = 0; k < NM; k++) begin
      wbm_adr_i[k*AW +: AW] = adr_of(k);
      wbm_dat_i[k*DW +: DW] = dat_of(k);
      wbm_sel_i[k*4 +: 4]   = 4'(k + 1);
    end

    // Reset held: bus and responses quiet even with requests and a slave ack.
    step();
    wbm_cyc_i = 4'b0001; wbm_stb_i = 4'b0001; wbs_ack_i = 1'b1;
    settle();
    check("rst_cyc", 32'(wbs_cyc_o), 32'h0);
    check("rst_ack", 32'(wbm_ack_o), 32'h0);
    check("rst_owner", 32'(owner_o), 32'h0);
    step();
    // First cycle after reset is still gated.
    wb_rst_i = 1'b0;
    settle();
    check("hold_cyc", 32'(wbs_cyc_o), 32'h0);
    check("hold_ack", 32'(wbm_ack_o), 32'h0);
    step();
    wbm_cyc_i = 4'b0000; wbm_stb_i = 4'b0000; wbs_ack_i = 1'b0;
    settle();
    check("park_owner", 32'(owner_o), 32'h0);
    check("park_cyc", 32'(wbs_cyc_o), 32'h0);
    step();

    // Master 2 alone requests.
    wbm_cyc_i = 4'b0100; wbm_stb_i = 4'b0100; wbm_we_i = 4'b0100;
    settle();
    check("m2_pre_owner", 32'(owner_o), 32'h0);
    check("m2_pre_cyc", 32'(wbs_cyc_o), 32'h0);
    step();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'h5A5A_0042;
    settle();
    check("m2_owner", 32'(owner_o), 32'h2);
    check("m2_adr", wbs_adr_o, 32'hA000_0020);
    check("m2_dat", wbs_dat_o, 32'hD000_0002);
    check("m2_sel", 32'(wbs_sel_o), 32'h3);
    check("m2_we", 32'(wbs_we_o), 32'h1);
    check("m2_cyc_stb", {30'd0, wbs_cyc_o, wbs_stb_o}, 32'h3);
    check("m2_ack", 32'(wbm_ack_o), 32'h4);
    check("m2_err", 32'(wbm_err_o), 32'h0);
    check("m2_rdata", wbm_dat_o, 32'h5A5A_0042);
    step();
    wbm_cyc_i = 4'b0000; wbm_stb_i = 4'b0000; wbm_we_i = 4'b0000; wbs_ack_i = 1'b0;
    settle();
    check("m2_rel_ack", 32'(wbm_ack_o), 32'h0);
    check("m2_rel_owner", 32'(owner_o), 32'h2);
    step();

    // Master 0 takes the bus and bursts 8 beats while 1 and 3 wait.
    wbm_cyc_i = 4'b0001; wbm_stb_i = 4'b0001; set_cti(0, 3'b010);
    settle();
    check("park2_owner", 32'(owner_o), 32'h2);
    check("park2_cyc", 32'(wbs_cyc_o), 32'h0);
    step();
    wbm_cyc_i = 4'b1011; wbm_stb_i = 4'b1011;
    for (int b = 0; b < 8; b++) begin
      set_cti(0, (b == 7) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      settle();
      check("burst_owner", 32'(owner_o), 32'h0);
      check("burst_ack", 32'(wbm_ack_o), 32'h1);
      check("burst_cti", 32'(wbs_cti_o), (b == 7) ? 32'h7 : 32'h2);
      step();
    end
    wbm_cyc_i = 4'b1010; wbm_stb_i = 4'b1010; wbs_ack_i = 1'b0; set_cti(0, 3'b000);
    settle();
    check("post_burst_owner", 32'(owner_o), 32'h0);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check("after_burst_owner1", 32'(owner_o), 32'h1);
    check("after_burst_adr1", wbs_adr_o, 32'hA000_0010);
    check("after_burst_ack1", 32'(wbm_ack_o), 32'h2);
    step();
    wbm_cyc_i = 4'b1000; wbm_stb_i = 4'b1000; wbs_ack_i = 1'b0;
    settle();
    check("m1_rel_owner", 32'(owner_o), 32'h1);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check("then_owner3", 32'(owner_o), 32'h3);
    check("then_adr3", wbs_adr_o, 32'hA000_0030);
    check("then_ack3", 32'(wbm_ack_o), 32'h8);
    step();

    // Owner 3 releases as master 0 raises cyc: wrap to 0 next cycle; slave err routed.
    wbm_cyc_i = 4'b0001; wbm_stb_i = 4'b0001; wbs_ack_i = 1'b0;
    settle();
    check("wrap_pre_owner", 32'(owner_o), 32'h3);
    check("wrap_pre_cyc", 32'(wbs_cyc_o), 32'h0);
    step();
    wbs_err_i = 1'b1;
    settle();
    check("wrap_owner", 32'(owner_o), 32'h0);
    check("wrap_cyc", 32'(wbs_cyc_o), 32'h1);
    check("wrap_err", 32'(wbm_err_o), 32'h1);
    check("wrap_ack", 32'(wbm_ack_o), 32'h0);
    step();
    wbm_cyc_i = 4'b0000; wbm_stb_i = 4'b0000; wbs_err_i = 1'b0;
    settle();
    check("wrap_rel_err", 32'(wbm_err_o), 32'h0);
    step();

    // All request continuously, each drops cyc for one cycle after its ack.
    for (int g = 0; g < 5; g++) begin
      wbm_cyc_i = 4'b1111; wbm_stb_i = 4'b1111; wbs_ack_i = 1'b1;
      settle();
      check("rr_owner", 32'(owner_o), 32'(ord[g]));
      check("rr_ack", 32'(wbm_ack_o), 32'h1 << ord[g]);
      step();
      wbm_cyc_i[ord[g]] = 1'b0; wbm_stb_i[ord[g]] = 1'b0; wbs_ack_i = 1'b0;
      settle();
      check("rr_hold_owner", 32'(owner_o), 32'(ord[g]));
      step();
    end

    // Owner 1 stalls with no slave response.
    wbm_cyc_i = 4'b0010; wbm_stb_i = 4'b0010;
`ifdef WB_RR_ARBITER_WDOG_EN
    for (int c = 0; c < 16; c++) begin
      settle();
      check("wd_err", 32'(wbm_err_o), (c == 15) ? 32'h2 : 32'h0);
      check("wd_cyc", 32'(wbs_cyc_o), 32'h1);
      step();
    end
    for (int c = 0; c < 2; c++) begin
      settle();
      check("wd_abort_cyc", 32'(wbs_cyc_o), 32'h0);
      check("wd_abort_err", 32'(wbm_err_o), 32'h0);
      step();
    end
`else
    for (int c = 0; c < 20; c++) begin
      settle();
      check("nowd_err", 32'(wbm_err_o), 32'h0);
      check("nowd_cyc", 32'(wbs_cyc_o), 32'h1);
      step();
    end
`endif
    wbm_cyc_i = 4'b0000; wbm_stb_i = 4'b0000;
    settle();
    check("stall_rel_owner", 32'(owner_o), 32'h1);
    step();

    // Reset in the middle of a burst by master 2.
    wbm_cyc_i = 4'b0100; wbm_stb_i = 4'b0100; set_cti(2, 3'b010);
    settle();
    check("m2b_pre_owner", 32'(owner_o), 32'h1);
    step();
    wbs_ack_i = 1'b1;
    settle();
    check("m2b_owner", 32'(owner_o), 32'h2);
    check("m2b_ack", 32'(wbm_ack_o), 32'h4);
    step();
    wb_rst_i = 1'b1;
    settle();
    check("mid_rst_cyc", 32'(wbs_cyc_o), 32'h0);
    check("mid_rst_ack", 32'(wbm_ack_o), 32'h0);
    step();
    wb_rst_i = 1'b0;
    settle();
    check("post_rst_owner", 32'(owner_o), 32'h0);
    check("post_rst_cyc", 32'(wbs_cyc_o), 32'h0);
    check("post_rst_ack", 32'(wbm_ack_o), 32'h0);
    step();
    wbs_ack_i = 1'b0;
    settle();
    check("regrant_owner", 32'(owner_o), 32'h2);
    check("regrant_cyc", 32'(wbs_cyc_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter NMASTERS, default 4, number of Wishbone masters (2..16).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; SEL width is DW/8.
REQ-004 SHALL have parameter TMO_W, default 8, watchdog counter width.
REQ-005 SHALL have port wb_clk_i, in, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port wb_rst_i, in, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports wbm_adr_i, in, NMASTERS*AW, packed per-master address; master k occupies slice k.
REQ-008 SHALL have ports wbm_dat_i, in, NMASTERS*DW, packed per-master write data.
REQ-009 SHALL have ports wbm_sel_i (NMASTERS*DW/8), wbm_cti_i (NMASTERS*3), wbm_bte_i (NMASTERS*2), in, packed per-master.
REQ-010 SHALL have ports wbm_cyc_i, wbm_stb_i, wbm_we_i, in, NMASTERS each, one bit per master.
REQ-011 SHALL have ports wbm_dat_o, out, DW, slave read data broadcast to all masters.
REQ-012 SHALL have ports wbm_ack_o, wbm_err_o, out, NMASTERS, per-master termination.
REQ-013 SHALL have ports wbs_adr_o (AW), wbs_dat_o (DW), wbs_sel_o, wbs_cti_o, wbs_bte_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, out, bus to slave.
REQ-014 SHALL have ports wbs_dat_i (DW), wbs_ack_i (1), wbs_err_i (1), in, slave response.
REQ-015 SHALL have port owner_o, out, $clog2(NMASTERS), current owner index.

Function
REQ-016 SHALL hold owner register; wbs_* outputs and wbs_dat_i/ack/err routing are combinational muxes of owner with zero latency.
REQ-017 SHALL drive wbm_ack_o[owner]=wbs_ack_i, wbm_err_o[owner]=wbs_err_i|watchdog error; every other master's ack/err SHALL be 0.
REQ-018 SHALL keep owner unchanged while wbm_cyc_i[owner]=1, including across cti bursts and back-to-back stb.
REQ-019 SHALL, when wbm_cyc_i[owner]=0, select next owner round-robin: first requesting index searching owner+1, owner+2, ... with wrap modulo NMASTERS.
REQ-020 SHALL park on current owner when no master requests; parked owner with cyc=0 drives wbs_cyc_o=0.
REQ-021 SHALL register owner change: a master released in cycle N lets the new owner drive wbs_* in cycle N+1.
REQ-022 SHALL, for a master raising cyc in the same cycle the owner drops cyc, grant it at N+1 if it is next in round-robin order.
REQ-023 SHALL use a state machine IDLE (owner cyc=0) / BUSY (owner cyc=1) / ABORT (watchdog fired), exported for bench via hierarchy only.

Reset
REQ-024 SHALL, with wb_rst_i=1 at a clock edge, set owner=0, state=IDLE, watchdog=0.
REQ-025 SHALL, during reset and the first cycle after, drive wbs_cyc_o=wbs_stb_o=0 and all wbm_ack_o/wbm_err_o=0; reset mid-transfer abandons it without ack.

Configuration
REQ-026 SHALL honour macro WB_RR_ARBITER_WDOG_EN.
REQ-027 SHALL with it defined: count cycles with owner cyc&stb=1 and no ack/err; at count 2^TMO_W-1 assert wbm_err_o[owner] one cycle, enter ABORT, force wbs_cyc_o=0 until owner drops cyc, then rearbitrate; counter clears on ack/err/owner change.
REQ-028 SHALL without it: no counter, no ABORT state, watchdog error term constant 0.

Structure
REQ-029 SHALL place state encoding, CTI constants (classic 000, end-of-burst 111) and the default TMO_W in shared package wb_arb_pkg.
REQ-030 SHALL implement the round-robin search in sub-module wb_rr_pick (inputs req vector, current owner; output next index, any-req flag).

Verification
REQ-031 SHALL test: reset, then master 2 only raises cyc/stb -> owner_o=2 next cycle, wbs_adr_o=master 2 address, wbm_ack_o=4'b0100 on slave ack.
REQ-032 SHALL test: owner 0 in 8-beat incrementing burst (cti=010, last 111) while masters 1,3 request -> owner stays 0 for all 8 acks, then 1, then 3.
REQ-033 SHALL test: NMASTERS=4, all request continuously, each drops cyc after one ack -> grant order 0,1,2,3,0 with one-cycle switch.
REQ-034 SHALL test: owner=3 releases, only master 0 requests -> wrap, owner_o=0 at N+1.
REQ-035 SHALL test: WDOG_EN, TMO_W=4, slave never acks -> wbm_err_o[owner] pulses at cycle 15, wbs_cyc_o=0 until master releases.
REQ-036 SHALL test: wb_rst_i asserted mid-burst of owner 2 -> owner_o=0, no ack issued, wbs_cyc_o=0.
